dp_loader: RTL and testbench
============================

Name: dp_loader

Overview:
- Writer side of the training-data RAM. Accepts a word-serial stream of data points, assembles each into one (MAX_FEATURES+1)*16-bit row and writes it into the dataset RAM read by the linear-regression trainer.
- Row layout matches the trainer's read format: bits [15:0] = y, bits [16*c +: 16] = feature c for c = 1..MAX_FEATURES.
- Asserts load_done once DPS rows are written. The trainer is held off until load_done is high.

Parameters:
- MAX_FEATURES, 6, features per data point; a row is MAX_FEATURES+1 words.
- DPS, 6, number of data points to load per run.
- DP_BITS, 4, RAM address width; requires DPS <= 2**DP_BITS.

Ports:
- CLK, input, 1, clock; all state changes on the rising edge.
- RST_N, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle pulse that begins a load run.
- in_valid, input, 1, stream word valid.
- in_ready, output, 1, loader can accept a word.
- in_data, input, 16, signed Q-format word (y first, then features 1..MAX_FEATURES).
- in_last, input, 1, marks the final word of a row.
- ram_we, output, 1, RAM write enable.
- ram_addr, output, DP_BITS, RAM row address.
- ram_wdata, output, (MAX_FEATURES+1)*16, assembled row.
- busy, output, 1, run in progress.
- load_done, output, 1, all DPS rows written; sticky.
- frame_err, output, 1, sticky framing error.

Behaviour:
- Reset (RST_N=0, asynchronous): all outputs 0, state IDLE, word index 0, row index 0, row register 0.
- States:
  - IDLE:
    - start=1 -> COLLECT; clears load_done, frame_err, word index and row index.
    - Otherwise stays in IDLE.
  - COLLECT:
    - in_ready=1, busy=1.
    - A word is accepted when in_valid && in_ready. It is stored at row bits [16*widx +: 16], then widx increments.
    - in_last=1 with widx==MAX_FEATURES: row complete -> WRITE.
    - in_last=1 with widx<MAX_FEATURES (short row): frame_err=1, row discarded, widx=0, stay in COLLECT.
    - in_last=0 with widx==MAX_FEATURES (long row): frame_err=1, row discarded, widx=0, stay in COLLECT. The next accepted word is treated as the y of a new row.
  - WRITE:
    - Exactly one cycle: ram_we=1, ram_addr=row index, ram_wdata=assembled row, in_ready=0.
    - Next state: if row index==DPS-1 -> DONE; else row index increments, widx=0 -> COLLECT.
  - DONE:
    - load_done=1, busy=0, in_ready=0.
    - start=1 -> COLLECT, beginning a new run that overwrites rows from address 0.
- Latency: ram_we rises in the cycle after the accepting edge of the last word of a row. Throughput is MAX_FEATURES+2 cycles per row with continuous valid.
- Addressing:
  - Rows are written to ascending addresses 0..DPS-1.
  - ram_addr holds its last value outside WRITE. ram_wdata is only meaningful while ram_we=1.
- start is ignored in COLLECT and WRITE; it cannot restart a run mid-load.
- in_valid while in_ready=0: word is not consumed; the source must hold it.
- frame_err:
  - Does not stop the run; only well-formed rows are written and counted.
  - Cleared only by start (from IDLE or DONE) or by reset.
- Reset mid-run: outputs drop to 0 immediately and no partial row is written. The RAM contents are left as-is and load_done=0 marks them invalid.
- No arithmetic on data: words are passed bit-exact; width is 16 per word.

Optional Feature:
- Macro: DP_LOADER_CHECKSUM_EN.
- Defined:
  - Adds output chk_sum[15:0], a wrapping 16-bit sum of every in_data word of rows written this run.
  - Words of discarded rows are excluded.
  - Reset value 0; cleared on an accepted start; valid when load_done=1.
- Undefined: no port and no accumulator logic.

Test Plan:
- Basic load:
  - Stimulus: start, then DPS=6 rows of 7 words with continuous in_valid. Row k = {y=0x0100*k, features 0x0010*k+c}.
  - Required: 6 ram_we pulses at addr 0..5 with exact rows; load_done=1 one cycle after the 6th write; busy=0.
- Backpressure and gaps:
  - Stimulus: random in_valid gaps while streaming.
  - Required: identical RAM writes to the basic load; no word lost or duplicated; in_ready=0 during every WRITE cycle.
- Short row:
  - Stimulus: row 2 sent as 4 words with in_last on word 4, then a correct row 2.
  - Required: frame_err=1; no write for the short row; the correct row written at addr 2; run completes with 6 writes.
- Long row:
  - Stimulus: 7th word of row 0 sent without in_last.
  - Required: frame_err=1; row 0 discarded; the next row written at addr 0.
- Reset mid-run:
  - Stimulus: RST_N=0 after 3 writes, then start and a full load.
  - Required: outputs 0 asynchronously; the new run writes addr 0..5.
- Checksum:
  - Condition: DP_LOADER_CHECKSUM_EN defined.
  - Stimulus: 6 rows with all words 0x0001.
  - Required: chk_sum=0x002A when load_done=1.

Source files
------------

// File: rtl/dp_loader.sv
// +------------------------------------------------------------------------+
// | Module   : dp_loader                                                   |
// | Purpose  : Writer side of the training-data RAM. Collects a            |
// |            word-serial stream (y first, then features 1..MAX_FEATURES) |
// |            into one row and writes DPS rows to ascending addresses.    |
// |            Malformed rows (short or long) raise a sticky frame_err     |
// |            and are dropped without consuming a row address.           |
// | Options  : DP_LOADER_CHECKSUM_EN adds chk_sum, a wrapping 16-bit sum  |
// |            of every word belonging to a row written this run.        |
// | Note     : DPS must not exceed 2**DP_BITS.                             |
// | Revision : 1.0 - initial release                                      |
// +------------------------------------------------------------------------+
`default_nettype none

module dp_loader #(
  parameter int MAX_FEATURES = 6,
  parameter int DPS          = 6,
  parameter int DP_BITS      = 4
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          start,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [15:0]                   in_data,
  input  logic                          in_last,
  output logic                          ram_we,
  output logic [DP_BITS-1:0]            ram_addr,
  output logic [(MAX_FEATURES+1)*16-1:0] ram_wdata,
  output logic                          busy,
  output logic                          load_done,
`ifdef DP_LOADER_CHECKSUM_EN
  output logic [15:0]                   chk_sum,
`endif
  output logic                          frame_err
);

  localparam int c_ROW_W  = (MAX_FEATURES + 1) * 16;
  localparam int c_WIDX_W = (MAX_FEATURES < 1) ? 1 : $clog2(MAX_FEATURES + 1);
  localparam logic [c_WIDX_W-1:0] c_LAST_WIDX = c_WIDX_W'(MAX_FEATURES);
  localparam logic [DP_BITS-1:0]  c_LAST_RIDX = DP_BITS'(DPS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [c_WIDX_W-1:0]   r_widx;
  logic [DP_BITS-1:0]    r_ridx;
  logic [DP_BITS-1:0]    r_ram_addr;
  logic [c_ROW_W-1:0]    r_row;
  logic                  r_load_done;
  logic                  r_frame_err;

  logic                  w_collect;
  logic                  w_accept;
  logic                  w_is_last_word;
  logic                  w_row_done;
  logic                  w_frame_bad;
  logic                  w_start_run;

  // A word is only ever taken while collecting; in_ready is a pure state decode.
  assign w_collect      = (r_state == S_COLLECT);
  assign w_accept       = in_valid && w_collect;
  assign w_is_last_word = (r_widx == c_LAST_WIDX);
  // Complete row: in_last lands exactly on the final feature slot.
  assign w_row_done     = w_accept && in_last && w_is_last_word;
  // Short row (early in_last) or long row (no in_last on the final slot).
  assign w_frame_bad    = w_accept && (in_last != w_is_last_word);
  // start is honoured only between runs.
  assign w_start_run    = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_row;
  assign load_done = r_load_done;
  assign frame_err = r_frame_err;

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and handshake/strobe outputs.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    busy        = 1'b0;
    ram_we      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_COLLECT;
        end
      end
      S_COLLECT: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_row_done) begin
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        ram_we = 1'b1;
        busy   = 1'b1;
        if (r_ridx == c_LAST_RIDX) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_COLLECT;
        end
      end
      S_DONE: begin
        if (start) begin
          w_state_nxt = S_COLLECT;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Row assembly, word/row indexing, address latch and sticky status flags.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_widx      <= '0;
      r_ridx      <= '0;
      r_ram_addr  <= '0;
      r_row       <= '0;
      r_load_done <= 1'b0;
      r_frame_err <= 1'b0;
    end else if (w_start_run) begin
      // ram_addr keeps its last value until the first write of the new run.
      r_widx      <= '0;
      r_ridx      <= '0;
      r_load_done <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_accept) begin
        // Decoded slot write; stale slots of a dropped row are always
        // overwritten before the next complete row reaches WRITE.
        for (int c = 0; c <= MAX_FEATURES; c++) begin
          if (r_widx == c_WIDX_W'(c)) begin
            r_row[16*c +: 16] <= in_data;
          end
        end
        if (w_frame_bad) begin
          r_frame_err <= 1'b1;
          r_widx      <= '0;
        end else if (w_row_done) begin
          r_widx     <= '0;
          r_ram_addr <= r_ridx;
        end else begin
          r_widx <= r_widx + c_WIDX_W'(1);
        end
      end
      if (r_state == S_WRITE) begin
        if (r_ridx == c_LAST_RIDX) begin
          r_load_done <= 1'b1;
        end else begin
          r_ridx <= r_ridx + DP_BITS'(1);
        end
      end
    end
  end

`ifdef DP_LOADER_CHECKSUM_EN
  logic [15:0] r_row_sum;
  logic [15:0] r_chk_sum;

  assign chk_sum = r_chk_sum;

  // Per-row partial sum, committed to the run total only once the row is complete.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_row_sum <= '0;
      r_chk_sum <= '0;
    end else if (w_start_run) begin
      r_row_sum <= '0;
      r_chk_sum <= '0;
    end else if (w_accept) begin
      if (w_frame_bad) begin
        r_row_sum <= '0;
      end else if (w_row_done) begin
        r_chk_sum <= r_chk_sum + r_row_sum + in_data;
        r_row_sum <= '0;
      end else begin
        r_row_sum <= r_row_sum + in_data;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dp_loader.sv
// +------------------------------------------------------------------------+
// | Module   : tb_dp_loader                                                |
// | Purpose  : Directed self-checking bench for dp_loader: reset, basic   |
// |            load, gaps with ignored start, short row, long row, reset  |
// |            mid-run and (with DP_LOADER_CHECKSUM_EN) the checksum.     |
// | Revision : 1.0 - initial release                                      |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_dp_loader;

  localparam int MF  = 6;
  localparam int DPS = 6;
  localparam int DPB = 4;
  localparam int RW  = (MF + 1) * 16;

  logic           CLK = 1'b0;
  logic           RST_N = 1'b0;
  logic           start = 1'b0;
  logic           in_valid = 1'b0;
  logic [15:0]    in_data = 16'h0;
  logic           in_last = 1'b0;
  logic           in_ready;
  logic           ram_we;
  logic [DPB-1:0] ram_addr;
  logic [RW-1:0]  ram_wdata;
  logic           busy;
  logic           load_done;
  logic           frame_err;
`ifdef DP_LOADER_CHECKSUM_EN
  logic [15:0]    chk_sum;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [DPB-1:0] wr_addr [$];
  logic [RW-1:0]  wr_data [$];
  int             rdy_viol = 0;

  dp_loader #(.MAX_FEATURES(MF), .DPS(DPS), .DP_BITS(DPB)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .busy      (busy),
    .load_done (load_done),
`ifdef DP_LOADER_CHECKSUM_EN
    .chk_sum   (chk_sum),
`endif
    .frame_err (frame_err)
  );

  always #5 CLK = ~CLK;

  // RAM write log, sampled mid-cycle.
  always @(negedge CLK) begin
    if (ram_we === 1'b1) begin
      wr_addr.push_back(ram_addr);
      wr_data.push_back(ram_wdata);
      if (in_ready !== 1'b0) rdy_viol++;
    end
  end

  function automatic logic [RW-1:0] exp_row(input int k);
    logic [RW-1:0] r;
    r = '0;
    r[15:0] = 16'(k * 256);
    for (int c = 1; c <= MF; c++) r[16*c +: 16] = 16'(k * 16 + c);
    return r;
  endfunction

  function automatic logic [15:0] word_of(input int k, input int j);
    return (j == 0) ? 16'(k * 256) : 16'(k * 16 + j);
  endfunction

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    rdy_viol = 0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_word(input logic [15:0] d, input logic last);
    int guard;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    guard    = 0;
    while (in_ready !== 1'b1 && guard < 100) begin
      @(negedge CLK);
      guard++;
    end
    if (guard >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_word_timeout: in_ready=%b after %0d cycles, required 1", in_ready, guard);
    end
    @(negedge CLK);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_row(input int k, input int nwords, input logic last_flag, input logic gaps);
    for (int j = 0; j < nwords; j++) begin
      if (gaps) repeat ((j + k) % 3) @(negedge CLK);
      send_word(word_of(k, j), last_flag && (j == nwords - 1));
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    n_checks++;
    if ({in_ready, ram_we, busy, load_done, frame_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: rdy/we/busy/done/ferr=%b, required 00000",
               {in_ready, ram_we, busy, load_done, frame_err});
    end
    n_checks++;
    if (ram_addr !== '0 || ram_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_bus: addr=%h wdata=%h, required 0", ram_addr, ram_wdata);
    end
    RST_N = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_start: busy=%b in_ready=%b, required 0 0", busy, in_ready);
    end
  endtask

  task automatic test_basic_load();
    clear_log();
    pulse_start();
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy: busy=%b in_ready=%b, required 1 1", busy, in_ready);
    end
    for (int k = 0; k < DPS; k++) send_row(k, MF + 1, 1'b1, 1'b0);
    n_checks++;
    if (ram_we !== 1'b1 || ram_addr !== 4'd5) begin
      n_fail++;
      $display("FAIL basic_last_write: we=%b addr=%0d, required 1 5", ram_we, ram_addr);
    end
    n_checks++;
    if (load_done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_early: load_done=%b, required 0", load_done);
    end
    @(negedge CLK);
    n_checks++;
    if (load_done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || ram_we !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: done=%b busy=%b rdy=%b we=%b, required 1 0 0 0",
               load_done, busy, in_ready, ram_we);
    end
    n_checks++;
    if (wr_addr.size() !== DPS) begin
      n_fail++;
      $display("FAIL basic_write_count: %0d, required %0d", wr_addr.size(), DPS);
    end
    for (int i = 0; i < wr_addr.size() && i < DPS; i++) begin
      n_checks++;
      if (wr_addr[i] !== DPB'(i) || wr_data[i] !== exp_row(i)) begin
        n_fail++;
        $display("FAIL basic_row%0d: addr=%0d data=%h, required addr=%0d data=%h",
                 i, wr_addr[i], wr_data[i], i, exp_row(i));
      end
    end
  endtask

  task automatic test_backpressure();
    clear_log();
    pulse_start();
    for (int k = 0; k < DPS; k++) begin
      send_row(k, MF + 1, 1'b1, 1'b1);
      if (k == 1) pulse_start();                    // lands in WRITE: ignored
      if (k == 3) begin
        @(negedge CLK);
        pulse_start();                              // lands in COLLECT: ignored
      end
    end
    @(negedge CLK);
    n_checks++;
    if (load_done !== 1'b1 || frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_done: load_done=%b frame_err=%b, required 1 0", load_done, frame_err);
    end
    n_checks++;
    if (rdy_viol !== 0) begin
      n_fail++;
      $display("FAIL bp_ready_in_write: %0d WRITE cycles with in_ready=1, required 0", rdy_viol);
    end
    n_checks++;
    if (wr_addr.size() !== DPS) begin
      n_fail++;
      $display("FAIL bp_write_count: %0d, required %0d", wr_addr.size(), DPS);
    end
    for (int i = 0; i < wr_addr.size() && i < DPS; i++) begin
      n_checks++;
      if (wr_addr[i] !== DPB'(i) || wr_data[i] !== exp_row(i)) begin
        n_fail++;
        $display("FAIL bp_row%0d: addr=%0d data=%h, required addr=%0d data=%h",
                 i, wr_addr[i], wr_data[i], i, exp_row(i));
      end
    end
  endtask

  task automatic test_short_row();
    clear_log();
    pulse_start();
    n_checks++;
    if (load_done !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL short_start_clear: load_done=%b frame_err=%b, required 0 0", load_done, frame_err);
    end
    send_row(0, MF + 1, 1'b1, 1'b0);
    send_row(1, MF + 1, 1'b1, 1'b0);
    send_row(2, 4, 1'b1, 1'b0);
    n_checks++;
    if (frame_err !== 1'b1 || ram_we !== 1'b0 || wr_addr.size() !== 2) begin
      n_fail++;
      $display("FAIL short_detect: frame_err=%b we=%b writes=%0d, required 1 0 2",
               frame_err, ram_we, wr_addr.size());
    end
    for (int k = 2; k < DPS; k++) send_row(k, MF + 1, 1'b1, 1'b0);
    @(negedge CLK);
    n_checks++;
    if (load_done !== 1'b1 || frame_err !== 1'b1) begin
      n_fail++;
      $display("FAIL short_done: load_done=%b frame_err=%b, required 1 1", load_done, frame_err);
    end
    n_checks++;
    if (wr_addr.size() !== DPS) begin
      n_fail++;
      $display("FAIL short_write_count: %0d, required %0d", wr_addr.size(), DPS);
    end
    for (int i = 0; i < wr_addr.size() && i < DPS; i++) begin
      n_checks++;
      if (wr_addr[i] !== DPB'(i) || wr_data[i] !== exp_row(i)) begin
        n_fail++;
        $display("FAIL short_row%0d: addr=%0d data=%h, required addr=%0d data=%h",
                 i, wr_addr[i], wr_data[i], i, exp_row(i));
      end
    end
  endtask

  task automatic test_long_row();
    clear_log();
    pulse_start();
    n_checks++;
    if (frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL long_start_clear: frame_err=%b, required 0", frame_err);
    end
    send_row(7, MF + 1, 1'b0, 1'b0);
    @(negedge CLK);
    n_checks++;
    if (frame_err !== 1'b1 || wr_addr.size() !== 0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL long_detect: frame_err=%b writes=%0d busy=%b, required 1 0 1",
               frame_err, wr_addr.size(), busy);
    end
    for (int k = 0; k < DPS; k++) send_row(k, MF + 1, 1'b1, 1'b0);
    @(negedge CLK);
    n_checks++;
    if (wr_addr.size() !== DPS || load_done !== 1'b1) begin
      n_fail++;
      $display("FAIL long_complete: writes=%0d load_done=%b, required %0d 1",
               wr_addr.size(), load_done, DPS);
    end
    for (int i = 0; i < wr_addr.size() && i < DPS; i++) begin
      n_checks++;
      if (wr_addr[i] !== DPB'(i) || wr_data[i] !== exp_row(i)) begin
        n_fail++;
        $display("FAIL long_row%0d: addr=%0d data=%h, required addr=%0d data=%h",
                 i, wr_addr[i], wr_data[i], i, exp_row(i));
      end
    end
  endtask

  task automatic test_reset_mid_run();
    clear_log();
    pulse_start();
    for (int k = 0; k < 3; k++) send_row(k, MF + 1, 1'b1, 1'b0);
    for (int j = 0; j < 3; j++) send_word(word_of(3, j), 1'b0);
    n_checks++;
    if (busy !== 1'b1 || wr_addr.size() !== 3) begin
      n_fail++;
      $display("FAIL midrst_pre: busy=%b writes=%0d, required 1 3", busy, wr_addr.size());
    end
    #2 RST_N = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, ram_we, busy, load_done, frame_err} !== 5'b0 || ram_addr !== '0) begin
      n_fail++;
      $display("FAIL midrst_async: rdy/we/busy/done/ferr=%b addr=%0d, required 00000 0",
               {in_ready, ram_we, busy, load_done, frame_err}, ram_addr);
    end
    repeat (3) @(negedge CLK);
    n_checks++;
    if (wr_addr.size() !== 3) begin
      n_fail++;
      $display("FAIL midrst_no_write: writes=%0d, required 3", wr_addr.size());
    end
    RST_N = 1'b1;
    @(negedge CLK);
    clear_log();
    pulse_start();
    for (int k = 0; k < DPS; k++) send_row(k, MF + 1, 1'b1, 1'b0);
    @(negedge CLK);
    n_checks++;
    if (wr_addr.size() !== DPS || load_done !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_rerun: writes=%0d load_done=%b, required %0d 1",
               wr_addr.size(), load_done, DPS);
    end
    for (int i = 0; i < wr_addr.size() && i < DPS; i++) begin
      n_checks++;
      if (wr_addr[i] !== DPB'(i) || wr_data[i] !== exp_row(i)) begin
        n_fail++;
        $display("FAIL midrst_row%0d: addr=%0d data=%h, required addr=%0d data=%h",
                 i, wr_addr[i], wr_data[i], i, exp_row(i));
      end
    end
  endtask

`ifdef DP_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    clear_log();
    pulse_start();
    n_checks++;
    if (chk_sum !== 16'h0) begin
      n_fail++;
      $display("FAIL chk_clear: chk_sum=%h, required 0000", chk_sum);
    end
    for (int j = 0; j < 3; j++) send_word(16'h0001, j == 2);   // discarded short row
    for (int k = 0; k < DPS; k++)
      for (int j = 0; j <= MF; j++) send_word(16'h0001, j == MF);
    @(negedge CLK);
    n_checks++;
    if (load_done !== 1'b1 || chk_sum !== 16'h002A) begin
      n_fail++;
      $display("FAIL chk_sum: load_done=%b chk_sum=%h, required 1 002a", load_done, chk_sum);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_load();
    test_backpressure();
    test_short_row();
    test_long_row();
    test_reset_mid_run();
`ifdef DP_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
